// File: rtl/sram_ctrl_pkg.sv
// Shared types and timing defaults for the 4x4 SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    WLON,
    SENSE,
    RESP
  } state_t;

  localparam int PRE_CYC_D = 1;
  localparam int WL_CYC_D  = 2;
  localparam int SA_CYC_D  = 1;
  localparam int CNT_W     = 4;

  // A phase of N cycles counts down from N-1 to 0 and leaves on zero.
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// Row address to one-hot wordline decode; all-zero when not enabled.
module sram_wl_decoder #(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 en,
  output logic [2**ADDR_W-1:0] wl
);

  always_comb begin
    wl = '0;
    if (en) wl[addr] = 1'b1;
  end

endmodule

// File: rtl/sram4x4_access_ctrl.sv
// Sequences precharge, wordline, write-driver and sense-amp timing for one
// SRAM row access at a time; every array-facing output comes from a flop.
module sram4x4_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 4,
  parameter int PRE_CYC = PRE_CYC_D,
  parameter int WL_CYC  = WL_CYC_D,
  parameter int SA_CYC  = SA_CYC_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [2**ADDR_W-1:0] wl,
  output logic                 pre_n,
  output logic                 wd_en,
  output logic [DATA_W-1:0]    wd_data,
  output logic                 sae,
  input  logic [DATA_W-1:0]    sa_out
);

  localparam int ROWS = 2**ADDR_W;

  if (ADDR_W != 2) begin : g_bad_addr_w
    $error("ADDR_W must be 2 for the 4x4 array");
  end
  if (PRE_CYC < 1 || PRE_CYC > 15) begin : g_bad_pre
    $error("PRE_CYC must be in 1..15");
  end
  if (WL_CYC < 1 || WL_CYC > 15) begin : g_bad_wl
    $error("WL_CYC must be in 1..15");
  end
  if (SA_CYC < 1 || SA_CYC > 15) begin : g_bad_sa
    $error("SA_CYC must be in 1..15");
  end

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               accept;
  logic               row_en;
  logic [ROWS-1:0]    wl_dec;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = PRECH;
          cnt_next   = phase_load(PRE_CYC);
        end
      end
      PRECH: begin
        if (cnt == '0) begin
          state_next = WLON;
          cnt_next   = phase_load(WL_CYC);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WLON: begin
        if (cnt == '0) begin
          state_next = we_q ? RESP : SENSE;
          cnt_next   = we_q ? '0 : phase_load(SA_CYC);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      SENSE: begin
        if (cnt == '0) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state itself.
  assign row_en = (state_next == WLON) || (state_next == SENSE);

  sram_wl_decoder #(.ADDR_W(ADDR_W)) u_wl_decoder (
    .addr (addr_q),
    .en   (row_en),
    .wl   (wl_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wl        <= '0;
      pre_n     <= 1'b1;
      wd_en     <= 1'b0;
      wd_data   <= '0;
      sae       <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      wl        <= wl_dec;
      pre_n     <= (state_next != PRECH);
      wd_en     <= (state_next == WLON) && we_q;
      sae       <= (state_next == SENSE);
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wd_data <= req_wdata;
      end
      if (state == SENSE && cnt == '0) rsp_rdata <= sa_out;
    end
  end

endmodule
